// File: rtl/cpu_types_pkg.sv
// Shared display types: segment word, blank pattern, nibble-to-segment
// decoder and the page geometry helpers used to size display ports.
package cpu_types_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic seg_t hex2seg(input logic [3:0] nib);
    seg_t seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h27;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Number of display pages needed to show a data_w-bit word.
  function automatic int num_pages(input int data_w, input int ndigits);
    return (data_w / 4 + ndigits - 1) / ndigits;
  endfunction

  // Width of the page index; at least one bit even for a single page.
  function automatic int page_width(input int data_w, input int ndigits);
    int p;
    p = num_pages(data_w, ndigits);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/hex_display_ctrl_key_sync_edge.sv
// Push-button front end: multi-flop synchroniser for an asynchronous
// active-low key followed by a falling-edge detector producing a one-cycle
// press pulse. Detection is held off until the chain and the edge register
// both reflect the real pin after reset, so a key held through reset is not
// mistaken for a fresh press.
module key_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic RST,
  input  logic key_n,
  output logic press
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [ARM_W-1:0]       arm_cnt;
  logic                   armed;

  // Shift the raw key through the synchroniser, remember the last settled
  // level and count cycles since reset until the detector may fire.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      sync_q  <= '1;
      prev_q  <= 1'b1;
      arm_cnt <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (arm_cnt != ARM_LAST) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  assign armed = (arm_cnt == ARM_LAST);
  assign press = armed & prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit active-low 7-segment driver. Captures a word on load, pages
// through words wider than the display with a push-button, optionally blanks
// leading zeros and blinks the digits whose nibble changed at the last load.
module hex_display_ctrl
  import cpu_types_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int NDIGITS      = 8,
  parameter int BLINK_CYCLES = 25000000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                                      CLOCK_50,
  input  logic                                      RST,
  input  logic [DATA_W-1:0]                         data,
  input  logic                                      load,
  input  logic                                      page_key_n,
  input  logic                                      blank_lz,
  output logic [7*NDIGITS-1:0]                      hex,
  output logic [page_width(DATA_W, NDIGITS)-1:0]    page,
  output logic                                      blink_active
);

  localparam int NIB    = DATA_W / 4;
  localparam int PAGES  = num_pages(DATA_W, NDIGITS);
  localparam int PAGE_W = page_width(DATA_W, NDIGITS);
  localparam int TOT    = PAGES * NDIGITS;
  localparam int CNT_W  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLINK_CYCLES - 1);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);

  logic [DATA_W-1:0]  shadow;
  logic [NIB-1:0]     mask;
  logic [NIB-1:0]     diff;
  logic [1:0]         phase;
  logic [CNT_W-1:0]   cnt;
  logic               press;

  logic [NIB-1:0]     nz;
  logic [NIB-1:0]     lz_blank;

  logic [4*TOT-1:0]   shadow_pad;
  logic [TOT-1:0]     mask_pad;
  logic [TOT-1:0]     lz_pad;
  logic [TOT-1:0]     valid_pad;

  logic [7*NDIGITS-1:0] seg_p0;

  key_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_key (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .key_n    (page_key_n),
    .press    (press)
  );

  // Per-nibble change flags between the incoming word and the shadow copy.
  always_comb begin
    diff = '0;
    for (int k = 0; k < NIB; k++) begin
      diff[k] = (data[k*4 +: 4] != shadow[k*4 +: 4]);
    end
  end

  // Shadow register holds the displayed word between load strobes.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= data;
    end
  end

  // Blink sequencer: a changed load restarts four half-phases of
  // BLINK_CYCLES each; after the fourth the mask clears and the timer idles.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      mask  <= '0;
      phase <= 2'd0;
      cnt   <= '0;
    end else if (load && (diff != '0)) begin
      mask  <= diff;
      phase <= 2'd0;
      cnt   <= '0;
    end else if (mask != '0) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (phase == 2'd3) begin
          mask  <= '0;
          phase <= 2'd0;
        end else begin
          phase <= phase + 2'd1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign blink_active = |mask;

  // Page index advances once per key press and wraps after the last page.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      page <= '0;
    end else if (press && (PAGES > 1)) begin
      if (page == PAGE_LAST) page <= '0;
      else                   page <= page + 1'b1;
    end
  end

  // Leading-zero map: a nibble is suppressed when it and every higher
  // nibble are zero, except nibble 0 so a zero word still shows one digit.
  always_comb begin
    nz       = '0;
    lz_blank = '0;
    for (int k = 0; k < NIB; k++) begin
      nz[k] = |shadow[k*4 +: 4];
    end
    for (int k = 0; k < NIB; k++) begin
      lz_blank[k] = blank_lz & ~nz[k] & ((nz >> (k + 1)) == '0) & (k != 0);
    end
  end

  // Pad the per-nibble views out to a whole number of pages so the digit
  // mux never indexes past the end; padding nibbles are marked invalid.
  always_comb begin
    shadow_pad             = '0;
    mask_pad               = '0;
    lz_pad                 = '0;
    valid_pad              = '0;
    shadow_pad[DATA_W-1:0] = shadow;
    mask_pad[NIB-1:0]      = mask;
    lz_pad[NIB-1:0]        = lz_blank;
    valid_pad[NIB-1:0]     = '1;
  end

  // Digit selection and blanking for the current page.
  always_comb begin
    seg_p0 = {NDIGITS{SEG_BLANK}};
    for (int i = 0; i < NDIGITS; i++) begin
      int n;
      n = int'(page) * NDIGITS + i;
      if (!valid_pad[n] || (mask_pad[n] && !phase[0]) || lz_pad[n]) begin
        seg_p0[i*7 +: 7] = SEG_BLANK;
      end else begin
        seg_p0[i*7 +: 7] = hex2seg(shadow_pad[n*4 +: 4]);
      end
    end
  end

  // ---- stage p0 -> pins: registered segment outputs ----
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      hex <= {NDIGITS{SEG_BLANK}};
    end else begin
      hex <= seg_p0;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: a 64-bit two-page instance and a
// 40-bit instance with a partial second page, both with a short blink.
module tb_hex_display_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        RST;

  logic [63:0] data64;
  logic        load64, key64_n, lz64;
  logic [55:0] hex64;
  logic        page64;
  logic        blink64;

  logic [39:0] data40;
  logic        load40, key40_n, lz40;
  logic [55:0] hex40;
  logic        page40;
  logic        blink40;

  int n_checks = 0;
  int n_errors = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  hex_display_ctrl #(
    .DATA_W(64), .NDIGITS(8), .BLINK_CYCLES(4), .SYNC_STAGES(2)
  ) u64 (
    .CLOCK_50(CLOCK_50), .RST(RST), .data(data64), .load(load64),
    .page_key_n(key64_n), .blank_lz(lz64), .hex(hex64), .page(page64),
    .blink_active(blink64)
  );

  hex_display_ctrl #(
    .DATA_W(40), .NDIGITS(8), .BLINK_CYCLES(4), .SYNC_STAGES(2)
  ) u40 (
    .CLOCK_50(CLOCK_50), .RST(RST), .data(data40), .load(load40),
    .page_key_n(key40_n), .blank_lz(lz40), .hex(hex40), .page(page40),
    .blink_active(blink40)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic [6:0] dig64(input int i);
    return hex64[i*7 +: 7];
  endfunction

  task automatic wait_idle64();
    for (int k = 0; k < 64 && blink64; k++) tick();
    check("idle64", 64'(blink64), 64'd0);
  endtask

  task automatic wait_idle40();
    for (int k = 0; k < 64 && blink40; k++) tick();
    check("idle40", 64'(blink40), 64'd0);
  endtask

  initial begin
    RST = 1'b1;
    data64 = '0; load64 = 1'b0; key64_n = 1'b1; lz64 = 1'b0;
    data40 = '0; load40 = 1'b0; key40_n = 1'b1; lz40 = 1'b0;
    tick(); tick();

    check("rst_hex64",   64'(hex64),   64'({8{7'h7F}}));
    check("rst_blink64", 64'(blink64), 64'd0);
    check("rst_page64",  64'(page64),  64'd0);

    // zero shadow, no blanking: every digit shows 0
    RST = 1'b0;
    tick();
    check("zero_hex64", 64'(hex64), 64'({8{7'h40}}));
    check("zero_hex40", 64'(hex40), 64'({8{7'h40}}));
    lz64 = 1'b1;
    tick();
    check("lz_zero_hex64", 64'(hex64), 64'({{7{7'h7F}}, 7'h40}));
    tick(); tick();

    // load A5 with leading-zero blanking; changed digits blink first
    data64 = 64'hA5; load64 = 1'b1;
    tick();
    load64 = 1'b0;
    check("a5_blink", 64'(blink64), 64'd1);
    tick();
    check("a5_blank_phase0", 64'(hex64), 64'({8{7'h7F}}));
    tick(); tick(); tick(); tick();
    check("a5_dig0", 64'(dig64(0)), 64'h12);
    check("a5_dig1", 64'(dig64(1)), 64'h08);
    check("a5_hi_blank", 64'(hex64[55:14]), 64'({6{7'h7F}}));
    wait_idle64();

    // blink timing for a single changed nibble
    lz64 = 1'b0;
    data64 = 64'h12; load64 = 1'b1;
    tick();
    load64 = 1'b0;
    wait_idle64();
    data64 = 64'h13; load64 = 1'b1;
    tick();
    load64 = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      logic [6:0] e0;
      tick();
      e0 = ((k >= 1 && k <= 4) || (k >= 9 && k <= 12)) ? 7'h7F : 7'h30;
      check($sformatf("blk_dig0_e%0d", k), 64'(dig64(0)), 64'(e0));
      check($sformatf("blk_dig1_e%0d", k), 64'(dig64(1)), 64'h79);
      check($sformatf("blk_act_e%0d", k), 64'(blink64), (k <= 15) ? 64'd1 : 64'd0);
    end

    // paging a 64-bit word
    data64 = 64'h1122_3344_5566_7788; load64 = 1'b1;
    tick();
    load64 = 1'b0;
    wait_idle64();
    tick();
    check("pg0_hex", 64'(hex64),
          64'({7'h12, 7'h12, 7'h02, 7'h02, 7'h78, 7'h78, 7'h00, 7'h00}));
    key64_n = 1'b0;
    tick(); tick();
    check("pg_before", 64'(page64), 64'd0);
    tick();
    check("pg_after3", 64'(page64), 64'd1);
    for (int k = 0; k < 7; k++) tick();
    check("pg_held", 64'(page64), 64'd1);
    check("pg1_hex", 64'(hex64),
          64'({7'h79, 7'h79, 7'h24, 7'h24, 7'h30, 7'h30, 7'h19, 7'h19}));
    key64_n = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    key64_n = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    key64_n = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("pg_wrap", 64'(page64), 64'd0);
    check("pg_wrap_hex", 64'(hex64),
          64'({7'h12, 7'h12, 7'h02, 7'h02, 7'h78, 7'h78, 7'h00, 7'h00}));

    // partial last page on the 40-bit instance
    data40 = 40'h12_3456_789A; load40 = 1'b1;
    tick();
    load40 = 1'b0;
    wait_idle40();
    tick();
    check("w40_pg0_hex", 64'(hex40),
          64'({7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h08}));
    key40_n = 1'b0;
    tick(); tick(); tick();
    check("w40_page", 64'(page40), 64'd1);
    tick();
    check("w40_pg1_hex", 64'(hex40), 64'({{6{7'h7F}}, 7'h79, 7'h24}));
    key40_n = 1'b1;
    tick(); tick();

    // reload during phase 1 of a running blink
    data64 = 64'h1122_3344_5566_7789; load64 = 1'b1;
    tick();
    load64 = 1'b0;
    tick(); tick(); tick(); tick();
    data64 = 64'h1122_3344_5566_6789; load64 = 1'b1;
    tick();
    load64 = 1'b0;
    tick();
    check("rl_dig0", 64'(dig64(0)), 64'h10);
    check("rl_dig3_blank", 64'(dig64(3)), 64'h7F);
    tick(); tick(); tick();
    check("rl_dig3_still_blank", 64'(dig64(3)), 64'h7F);
    tick();
    check("rl_dig3_shown", 64'(dig64(3)), 64'h02);
    check("rl_blink", 64'(blink64), 64'd1);

    // asynchronous reset mid-blink, with the key held through it
    key64_n = 1'b0;
    RST = 1'b1;
    #2;
    check("arst_hex64", 64'(hex64), 64'({8{7'h7F}}));
    check("arst_blink64", 64'(blink64), 64'd0);
    check("arst_page40", 64'(page40), 64'd0);
    tick(); tick();
    RST = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("held_key_page", 64'(page64), 64'd0);
    check("post_rst_hex64", 64'(hex64), 64'({8{7'h40}}));
    key64_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
